md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: number of cycles a MULT/MULTU holds Busy.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: number of cycles a DIV/DIVU holds Busy.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port E_MDOp, input, 4: HI/LO operation of the instruction in E; encoding per REQ-034.
REQ-006 SHALL have port E_A, input, 32: forwarded rs operand.
REQ-007 SHALL have port E_B, input, 32: forwarded rt operand.
REQ-008 SHALL have port D_UseMD, input, 1: instruction in D is any of mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have port HI, output, 32: architectural HI register.
REQ-010 SHALL have port LO, output, 32: architectural LO register.
REQ-011 SHALL have port Busy, output, 1: multiply/divide operation in progress.
REQ-012 SHALL have port D_MDStall, output, 1: stall request to the hazard unit.

Function
REQ-013 SHALL implement two FSM states, IDLE and BUSY, plus a down-counter (width ≥ 4 bits) and 64-bit result hold register {tmpHI, tmpLO}.
REQ-014 Start condition: IDLE and E_MDOp in {MULT, MULTU, DIV, DIVU}; on that edge SHALL latch the result of REQ-019..REQ-022, load counter with MULT_CYCLES or DIV_CYCLES, enter BUSY.
REQ-015 In BUSY, each edge SHALL decrement the counter; on the edge where counter==1, SHALL copy tmpHI/tmpLO into HI/LO, clear counter, and return to IDLE.
REQ-016 Busy SHALL be 1 exactly while in BUSY: N cycles for an N-cycle operation; HI/LO change on the same edge Busy falls.
REQ-017 MTHI/MTLO in IDLE SHALL write E_A into HI/LO respectively on that edge; the other register is unchanged.
REQ-018 E_MDOp values other than NONE while in BUSY SHALL be ignored (the hazard unit prevents them; no queuing).
REQ-019 MULT: {HI,LO} = signed 32x32 to 64-bit product; MULTU: unsigned product.
REQ-020 DIV/DIVU: LO = quotient, HI = remainder; signed forms truncate toward zero, and the remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL still run DIV_CYCLES with Busy, then leave HI/LO unchanged.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-023 D_MDStall SHALL be combinational: D_UseMD & (Busy | start condition of REQ-014).
REQ-024 HI/LO outputs SHALL be register outputs, with no combinational path from E_A/E_B.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, counter=0, tmpHI=tmpLO=0, HI=LO=0, Busy=0.
REQ-026 reset SHALL take priority over any start, MTHI/MTLO or commit on the same edge.
REQ-027 reset during BUSY SHALL abort the operation with no commit; HI/LO read 0 afterwards.
REQ-028 After reset deasserts, a start SHALL be accepted on the first edge.

Structure
REQ-029 Shared package md_defs SHALL hold the E_MDOp codes.
REQ-030 Shared package md_defs SHALL hold the MULT_CYCLES and DIV_CYCLES defaults.
REQ-031 Shared package md_defs SHALL hold the IDLE/BUSY state encoding.
REQ-032 The 64-bit product/quotient/remainder computation SHALL live in one combinational sub-module, md_calc.
REQ-033 md_ctrl SHALL own the FSM, counter, hold register, HI/LO and stall logic.
REQ-034 Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7-15 treated as NONE.

Verification
REQ-035 MULT E_A=0xFFFFFFFE, E_B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-037 DIV E_A=-7, E_B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU E_A=7, E_B=0 with prior HI=LO=0x12345678 -> Busy 10 cycles; HI/LO stay 0x12345678.
REQ-039 D_UseMD=1 held during MULT -> D_MDStall=1 on the start cycle and all 5 Busy cycles, 0 after; MTHI issued mid-BUSY leaves HI unchanged.
REQ-040 reset asserted on cycle 3 of a DIV -> next cycle Busy=0, HI=LO=0; MTLO 0xA5A5A5A5 on the following edge -> LO=0xA5A5A5A5.

Source files
------------

// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide controller:
// op codes, default latencies and FSM state encoding.
package md_defs;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply / divide datapath. Results default to the
// current HI/LO so a divide by zero commits the registers unchanged.
module md_calc
    import md_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    assign sa64   = {{32{a[31]}}, a};
    assign sb64   = {{32{b[31]}}, b};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 needs no special case.
    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn   = (op == OP_DIV);
    assign neg_a = sgn & a[31];
    assign neg_b = sgn & b[31];
    assign mag_a = neg_a ? (~a + 32'd1) : a;
    assign mag_b = neg_b ? (~b + 32'd1) : b;
    assign uq    = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    assign ur    = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    assign quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    assign rem   = neg_a ? (~ur + 32'd1) : ur;

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO controller: latches a mult/div result at start, holds Busy for a
// fixed latency, then commits it to the architectural HI/LO registers.
module md_ctrl
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_UseMD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        D_MDStall
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    md_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        tmp_hi, tmp_hi_n;
    logic [31:0]        tmp_lo, tmp_lo_n;
    logic [31:0]        hi_q, hi_n;
    logic [31:0]        lo_q, lo_n;
    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;
    logic               start;

    md_calc u_calc (
        .op     (E_MDOp),
        .a      (E_A),
        .b      (E_B),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    assign start     = (state == IDLE) && is_start_op(E_MDOp);
    assign Busy      = (state == BUSY);
    assign D_MDStall = D_UseMD & (Busy | start);
    assign HI        = hi_q;
    assign LO        = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tmp_hi <= tmp_hi_n;
            tmp_lo <= tmp_lo_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tmp_hi_n = tmp_hi;
        tmp_lo_n = tmp_lo;
        hi_n     = hi_q;
        lo_n     = lo_q;
        case (state)
            IDLE: begin
                if (start) begin
                    tmp_hi_n = calc_hi;
                    tmp_lo_n = calc_lo;
                    cnt_n    = is_div_op(E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_n  = BUSY;
                end else if (E_MDOp == OP_MTHI) begin
                    hi_n = E_A;
                end else if (E_MDOp == OP_MTLO) begin
                    lo_n = E_A;
                end
            end
            BUSY: begin
                // Any op arriving while busy is dropped; the hazard unit stalls it.
                if (cnt == CNT_W'(1)) begin
                    hi_n    = tmp_hi;
                    lo_n    = tmp_lo;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: a cycle-level reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                           DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_MDOp = NONE;
    logic [31:0] E_A = '0;
    logic [31:0] E_B = '0;
    logic        D_UseMD = 1'b0;
    logic [31:0] HI, LO;
    logic        Busy, D_MDStall;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDOp    (E_MDOp),
        .E_A       (E_A),
        .E_B       (E_B),
        .D_UseMD   (D_UseMD),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .D_MDStall (D_MDStall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Reference model: remaining busy cycles plus the pending result to commit.
    int          m_rem = 0;
    bit          m_upd = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk) begin
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(E_A));
        sb = longint'($signed(E_B));
        if (reset) begin
            m_rem = 0; m_upd = 0; m_hi = '0; m_lo = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_upd) begin m_hi = p_hi; m_lo = p_lo; end
        end else begin
            case (E_MDOp)
                MULT:  begin p = 64'(sa * sb); {p_hi, p_lo} = p; m_upd = 1; m_rem = MC; end
                MULTU: begin p = {32'd0, E_A} * {32'd0, E_B}; {p_hi, p_lo} = p; m_upd = 1; m_rem = MC; end
                DIV: begin
                    m_upd = (E_B != 0); m_rem = DC;
                    if (m_upd) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
                end
                DIVU: begin
                    m_upd = (E_B != 0); m_rem = DC;
                    if (m_upd) begin p_lo = E_A / E_B; p_hi = E_A % E_B; end
                end
                MTHI: m_hi = E_A;
                MTLO: m_lo = E_A;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_hi", HI, m_hi);
            chk("cmp_lo", LO, m_lo);
            chk("cmp_busy", {31'd0, Busy}, {31'd0, m_rem > 0});
            chk("cmp_stall", {31'd0, D_MDStall},
                {31'd0, D_UseMD && (m_rem > 0 || (E_MDOp >= MULT && E_MDOp <= DIVU))});
        end
    end

    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_md);
        E_MDOp = op; E_A = a; E_B = b; D_UseMD = use_md;
        @(posedge clk); #1;
    endtask

    // Counts Busy cycles after a start edge; optionally issues MTHI on the 2nd one.
    task automatic run_busy(input logic use_md, input bit inject_mthi, output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            if (inject_mthi && n == 2) cyc(MTHI, 32'hDEADBEEF, 0, use_md);
            else cyc(NONE, 0, 0, use_md);
        end
        if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        cyc(NONE, 0, 0, 0);
        cmp_en = 1'b1;
        cyc(NONE, 0, 0, 0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b0;

        // MULT with stall tracking and an ignored MTHI mid-operation
        E_MDOp = MULT; E_A = 32'hFFFFFFFE; E_B = 32'd3; D_UseMD = 1'b1; #1;
        chk("stall_start", {31'd0, D_MDStall}, 32'd1);
        cyc(MULT, 32'hFFFFFFFE, 32'd3, 1);
        run_busy(1, 1, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        chk("stall_after", {31'd0, D_MDStall}, 32'd0);

        cyc(MULTU, 32'hFFFFFFFE, 32'd3, 0);
        run_busy(0, 0, n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", HI, 32'h00000002);
        chk("multu_lo", LO, 32'hFFFFFFFA);

        cyc(DIV, 32'hFFFFFFF9, 32'd2, 0);
        run_busy(0, 0, n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        cyc(MTHI, 32'h12345678, 0, 0);
        cyc(MTLO, 32'h12345678, 0, 0);
        cyc(DIVU, 32'd7, 32'd0, 0);
        run_busy(0, 0, n);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_hi", HI, 32'h12345678);
        chk("div0_lo", LO, 32'h12345678);

        cyc(DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        run_busy(0, 0, n);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'h00000000);

        cyc(DIV, 32'd7, 32'hFFFFFFFE, 0);
        run_busy(0, 0, n);
        chk("div_negb_lo", LO, 32'hFFFFFFFD);
        chk("div_negb_hi", HI, 32'h00000001);

        cyc(DIVU, 32'd100, 32'd7, 0);
        run_busy(0, 0, n);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        for (int op = 7; op < 16; op++) begin
            cyc(4'(op), 32'hCAFEF00D, 32'd1, 0);
            chk("undef_busy", {31'd0, Busy}, 32'd0);
            chk("undef_lo", LO, 32'd14);
        end

        // Reset on the third cycle of a DIV aborts it
        cyc(DIV, 32'd50, 32'd5, 0);
        cyc(NONE, 0, 0, 0);
        cyc(NONE, 0, 0, 0);
        reset = 1'b1;
        cyc(NONE, 0, 0, 0);
        reset = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        cyc(MTLO, 32'hA5A5A5A5, 0, 0);
        chk("mtlo_lo", LO, 32'hA5A5A5A5);
        chk("mtlo_hi", HI, 32'h0);

        // Reset beats MTHI on the same edge; start accepted right after reset
        reset = 1'b1;
        cyc(MTHI, 32'h11111111, 0, 0);
        reset = 1'b0;
        chk("rst_prio_hi", HI, 32'h0);
        cyc(MULT, 32'd6, 32'd7, 0);
        chk("post_rst_busy", {31'd0, Busy}, 32'd1);
        run_busy(0, 0, n);
        chk("post_rst_lo", LO, 32'd42);

        cyc(NONE, 0, 0, 0);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
